// File: rtl/alu_hilo.sv
// -----------------------------------------------------------------------------
// alu_hilo
//
// Multi-cycle HI/LO unit placed beside the master ALU in the execute stage.
// It owns the architectural HI and LO registers and executes MULT/MULTU,
// DIV/DIVU, MTHI/MTLO and MFHI/MFLO, one operation at a time.
//
// Ports
//   clk       in   1   sole clock, rising edge
//   rst       in   1   asynchronous, active-low reset
//   op_valid  in   1   operation request this cycle
//   alu_op    in   6   operation code
//   src_a     in  32   rs operand (dividend / multiplicand / MTHI-MTLO data)
//   src_b     in  32   rt operand (divisor / multiplier)
//   flush     in   1   abort the in-flight op and drop any request this cycle
//   op_ready  out  1   high when idle; accept = op_valid & op_ready & ~flush
//   busy      out  1   inverse of op_ready
//   done      out  1   one-cycle pulse in the cycle after an op completes
//   result    out 32   MFHI/MFLO data, valid while done; 0 for other ops
//   hi, lo    out 32   architectural HI/LO
//
// Build option
//   HILO_FAST_MUL_EN  defined: MULT/MULTU use a single-cycle 32x32 multiplier
//                     and complete like MTHI. Undefined: 32-step shift-add.
//   Division is always the 32-step restoring divider.
//
// Timing summary
//   Single-cycle ops write HI/LO/result at the accept edge, done next cycle.
//   Iterative ops step once per edge for 32 edges; HI/LO are written on the
//   32nd step edge and done pulses in the following cycle, in which op_ready
//   is already high so a new op can be accepted back-to-back.
// -----------------------------------------------------------------------------
module alu_hilo (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [5:0]  alu_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        op_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // Operation codes, same values as the shared alu_op.vh definitions.
    localparam logic [5:0] ALU_MFHI  = 6'h10;
    localparam logic [5:0] ALU_MTHI  = 6'h11;
    localparam logic [5:0] ALU_MFLO  = 6'h12;
    localparam logic [5:0] ALU_MTLO  = 6'h13;
    localparam logic [5:0] ALU_MULT  = 6'h18;
    localparam logic [5:0] ALU_MULTU = 6'h19;
    localparam logic [5:0] ALU_DIV   = 6'h1A;
    localparam logic [5:0] ALU_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t      state_q, state_d;

    // Architectural and output registers
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;

    // Iteration datapath shared by multiply and divide.
    //   multiply: work_hi = running upper product, work_lo = multiplier being
    //             shifted out (low product bits shift in), operand = |multiplicand|
    //   divide:   work_hi = partial remainder, work_lo = dividend shifting out
    //             while quotient bits shift in, operand = |divisor|
    logic [31:0] work_hi_q, work_hi_d;
    logic [31:0] work_lo_q, work_lo_d;
    logic [31:0] operand_q, operand_d;
    logic        neg_lo_q, neg_lo_d;   // negate product / quotient at the end
    logic        neg_hi_q, neg_hi_d;   // negate remainder at the end
    logic [4:0]  count_q, count_d;     // steps already taken

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic        accept;
    logic        op_is_mul;
    logic        op_is_div;
    logic        op_signed;
    logic        divisor_zero;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        last_step;

    always_comb begin
        accept       = op_valid & op_ready & ~flush;
        op_is_mul    = (alu_op == ALU_MULT) || (alu_op == ALU_MULTU);
        op_is_div    = (alu_op == ALU_DIV)  || (alu_op == ALU_DIVU);
        op_signed    = (alu_op == ALU_MULT) || (alu_op == ALU_DIV);
        divisor_zero = (src_b == 32'd0);
        abs_a        = (op_signed && src_a[31]) ? (32'd0 - src_a) : src_a;
        abs_b        = (op_signed && src_b[31]) ? (32'd0 - src_b) : src_b;
        last_step    = (count_q == 5'd31);
    end

`ifdef HILO_FAST_MUL_EN
    // Sign-extending to 64 bits and keeping the low 64 bits of the product
    // gives the correct two's-complement result for MULT.
    logic [63:0] fast_prod;

    always_comb begin
        if (op_signed) begin
            fast_prod = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
        end else begin
            fast_prod = {32'd0, src_a} * {32'd0, src_b};
        end
    end
`endif

    // -------------------------------------------------------------------------
    // One shift-add multiply step
    // -------------------------------------------------------------------------
    logic [32:0] mul_sum;
    logic [31:0] mul_hi_n;
    logic [31:0] mul_lo_n;
    logic [63:0] mul_mag;
    logic [63:0] mul_final;

    always_comb begin
        mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, operand_q} : 33'd0);
        mul_hi_n  = mul_sum[32:1];
        mul_lo_n  = {mul_sum[0], work_lo_q[31:1]};
        mul_mag   = {mul_hi_n, mul_lo_n};
        mul_final = neg_lo_q ? (64'd0 - mul_mag) : mul_mag;
    end

    // -------------------------------------------------------------------------
    // One restoring divide step
    // -------------------------------------------------------------------------
    // The shifted remainder can reach 33 bits only when the divisor is above
    // 2^31, in which case the subtraction always succeeds and the difference
    // fits back into 32 bits.
    logic [32:0] div_shift;
    logic        div_ge;
    logic [32:0] div_diff;
    logic [31:0] div_rem_n;
    logic [31:0] div_quo_n;
    logic [31:0] div_lo_final;
    logic [31:0] div_hi_final;

    always_comb begin
        div_shift    = {work_hi_q, work_lo_q[31]};
        div_ge       = (div_shift >= {1'b0, operand_q});
        div_diff     = div_shift - {1'b0, operand_q};
        div_rem_n    = div_ge ? div_diff[31:0] : div_shift[31:0];
        div_quo_n    = {work_lo_q[30:0], div_ge};
        div_lo_final = neg_lo_q ? (32'd0 - div_quo_n) : div_quo_n;
        div_hi_final = neg_hi_q ? (32'd0 - div_rem_n) : div_rem_n;
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
`ifndef HILO_FAST_MUL_EN
                    if (op_is_mul) begin
                        state_d = ST_MUL;
                    end
`endif
                    // Divide by zero resolves at the accept edge.
                    if (op_is_div && !divisor_zero) begin
                        state_d = ST_DIV;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                // Flush wins over completion, including on the final step.
                if (flush || last_step) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        op_ready = (state_q == ST_IDLE);
        busy     = (state_q != ST_IDLE);
    end

    // -------------------------------------------------------------------------
    // Datapath next-state
    // -------------------------------------------------------------------------
    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        result_d  = result_q;
        done_d    = 1'b0;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        operand_d = operand_q;
        neg_lo_d  = neg_lo_q;
        neg_hi_d  = neg_hi_q;
        count_d   = count_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    count_d = 5'd0;
                    case (alu_op)
                        ALU_MTHI: begin
                            hi_d     = src_a;
                            result_d = 32'd0;
                            done_d   = 1'b1;
                        end
                        ALU_MTLO: begin
                            lo_d     = src_a;
                            result_d = 32'd0;
                            done_d   = 1'b1;
                        end
                        ALU_MFHI: begin
                            result_d = hi_q;
                            done_d   = 1'b1;
                        end
                        ALU_MFLO: begin
                            result_d = lo_q;
                            done_d   = 1'b1;
                        end
                        ALU_MULT, ALU_MULTU: begin
`ifdef HILO_FAST_MUL_EN
                            hi_d     = fast_prod[63:32];
                            lo_d     = fast_prod[31:0];
                            result_d = 32'd0;
                            done_d   = 1'b1;
`else
                            // Result is held until the final step.
                            work_hi_d = 32'd0;
                            work_lo_d = abs_b;
                            operand_d = abs_a;
                            neg_lo_d  = op_signed & (src_a[31] ^ src_b[31]);
                            neg_hi_d  = 1'b0;
`endif
                        end
                        ALU_DIV, ALU_DIVU: begin
                            if (divisor_zero) begin
                                hi_d     = src_a;
                                lo_d     = 32'hFFFF_FFFF;
                                result_d = 32'd0;
                                done_d   = 1'b1;
                            end else begin
                                work_hi_d = 32'd0;
                                work_lo_d = abs_a;
                                operand_d = abs_b;
                                neg_lo_d  = op_signed & (src_a[31] ^ src_b[31]);
                                neg_hi_d  = op_signed & src_a[31];
                            end
                        end
                        default: begin
                            // Unknown opcode: acknowledged without side effects.
                            result_d = 32'd0;
                            done_d   = 1'b1;
                        end
                    endcase
                end
            end

            ST_MUL: begin
                if (!flush) begin
                    work_hi_d = mul_hi_n;
                    work_lo_d = mul_lo_n;
                    count_d   = count_q + 5'd1;
                    if (last_step) begin
                        hi_d     = mul_final[63:32];
                        lo_d     = mul_final[31:0];
                        result_d = 32'd0;
                        done_d   = 1'b1;
                    end
                end
            end

            ST_DIV: begin
                if (!flush) begin
                    work_hi_d = div_rem_n;
                    work_lo_d = div_quo_n;
                    count_d   = count_q + 5'd1;
                    if (last_step) begin
                        hi_d     = div_hi_final;
                        lo_d     = div_lo_final;
                        result_d = 32'd0;
                        done_d   = 1'b1;
                    end
                end
            end

            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            result_q  <= 32'd0;
            done_q    <= 1'b0;
            work_hi_q <= 32'd0;
            work_lo_q <= 32'd0;
            operand_q <= 32'd0;
            neg_lo_q  <= 1'b0;
            neg_hi_q  <= 1'b0;
            count_q   <= 5'd0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            result_q  <= result_d;
            done_q    <= done_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            operand_q <= operand_d;
            neg_lo_q  <= neg_lo_d;
            neg_hi_q  <= neg_hi_d;
            count_q   <= count_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;
    assign hi     = hi_q;
    assign lo     = lo_q;

endmodule

// File: tb/tb_alu_hilo.sv
// -----------------------------------------------------------------------------
// tb_alu_hilo
//
// Random and directed stimulus for alu_hilo. A behavioural model computes
// HI/LO/result with plain 64-bit arithmetic and keeps a timeline (busy window,
// done cycle) per accepted op; one compare process checks every output on
// every falling edge. A few literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_alu_hilo;

    localparam logic [5:0] OP_MFHI  = 6'h10;
    localparam logic [5:0] OP_MTHI  = 6'h11;
    localparam logic [5:0] OP_MFLO  = 6'h12;
    localparam logic [5:0] OP_MTLO  = 6'h13;
    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_MULTU = 6'h19;
    localparam logic [5:0] OP_DIV   = 6'h1A;
    localparam logic [5:0] OP_DIVU  = 6'h1B;

`ifdef HILO_FAST_MUL_EN
    localparam int MUL_LAT  = 1;
    localparam int MUL_WAIT = 0;
`else
    localparam int MUL_LAT  = 32;
    localparam int MUL_WAIT = 32;
`endif

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        op_valid = 1'b0;
    logic [5:0]  alu_op   = 6'd0;
    logic [31:0] src_a    = 32'd0;
    logic [31:0] src_b    = 32'd0;
    logic        flush    = 1'b0;
    logic        op_ready;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;

    alu_hilo dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .alu_op   (alu_op),
        .src_a    (src_a),
        .src_b    (src_b),
        .flush    (flush),
        .op_ready (op_ready),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Committed model state and the pending op's outcome.
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_result = 32'd0;
    logic [31:0] p_hi = 32'd0, p_lo = 32'd0, p_result = 32'd0;
    int busy_lo  = 1;
    int busy_hi  = 0;
    int done_cyc = -1;
    int last_lat = 1;

    logic [5:0] ops [8] = '{OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO,
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Architectural outcome of one op, from its definition.
    function automatic void model(input logic [5:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic [31:0] chi,
                                  input logic [31:0] clo, output logic [31:0] nhi,
                                  output logic [31:0] nlo, output logic [31:0] nres,
                                  output int lat);
        longint sa, sb, q, r;
        logic [63:0] p;
        nhi  = chi;
        nlo  = clo;
        nres = 32'd0;
        lat  = 1;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        case (op)
            OP_MTHI: nhi = a;
            OP_MTLO: nlo = a;
            OP_MFHI: nres = chi;
            OP_MFLO: nres = clo;
            OP_MULT: begin
                p   = 64'(sa * sb);
                nhi = p[63:32];
                nlo = p[31:0];
                lat = MUL_LAT;
            end
            OP_MULTU: begin
                p   = {32'd0, a} * {32'd0, b};
                nhi = p[63:32];
                nlo = p[31:0];
                lat = MUL_LAT;
            end
            OP_DIV, OP_DIVU: begin
                if (b == 32'd0) begin
                    nhi = a;
                    nlo = 32'hFFFF_FFFF;
                end else begin
                    if (op == OP_DIV) begin
                        q = sa / sb;
                        r = sa % sb;
                    end else begin
                        q = longint'({32'd0, a}) / longint'({32'd0, b});
                        r = longint'({32'd0, a}) % longint'({32'd0, b});
                    end
                    nlo = 32'(q);
                    nhi = 32'(r);
                    lat = 32;
                end
            end
            default: ;
        endcase
    endfunction

    // Compare process: every falling edge, every output.
    always @(negedge clk) begin : cmp
        logic e_busy;
        logic e_done;
        if (!rst) begin
            m_hi     = 32'd0;
            m_lo     = 32'd0;
            m_result = 32'd0;
        end else if (cyc == done_cyc) begin
            m_hi     = p_hi;
            m_lo     = p_lo;
            m_result = p_result;
        end
        e_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
        e_done = (cyc == done_cyc);
        check("done",     64'(done),     64'(e_done));
        check("busy",     64'(busy),     64'(e_busy));
        check("op_ready", 64'(op_ready), 64'(!e_busy));
        check("hi",       64'(hi),       64'(m_hi));
        check("lo",       64'(lo),       64'(m_lo));
        check("result",   64'(result),   64'(m_result));
    end

    task automatic slot();
        @(negedge clk);
        #1;
    endtask

    // Waits until the unit is idle, presents one op for one cycle, and records
    // the expected timeline. Returns in the first cycle after the accept edge.
    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] nh, nl, nr;
        int lat;
        int c0;
        while (cyc <= busy_hi) begin
            src_a = $urandom;
            src_b = $urandom;
            slot();
        end
        model(op, a, b, m_hi, m_lo, nh, nl, nr, lat);
        op_valid = 1'b1;
        alu_op   = op;
        src_a    = a;
        src_b    = b;
        c0       = cyc + 1;
        last_lat = lat;
        p_hi     = nh;
        p_lo     = nl;
        p_result = nr;
        busy_lo  = c0;
        busy_hi  = (lat == 1) ? c0 - 1 : c0 + 31;
        done_cyc = (lat == 1) ? c0 : c0 + 32;
        slot();
        op_valid = 1'b0;
        alu_op   = 6'($urandom);
        src_a    = $urandom;
        src_b    = $urandom;
    endtask

    // Flush k cycles after the accept, i.e. aborting step k+1.
    task automatic flush_after(input int k);
        repeat (k) slot();
        flush    = 1'b1;
        op_valid = 1'($urandom_range(0, 1));
        busy_hi  = cyc;
        done_cyc = -1;
        slot();
        flush    = 1'b0;
        op_valid = 1'b0;
    endtask

    task automatic idle_flush(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        while (cyc <= busy_hi) slot();
        op_valid = 1'b1;
        flush    = 1'b1;
        alu_op   = op;
        src_a    = a;
        src_b    = b;
        slot();
        op_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic wait_done();
        int g = 0;
        while (cyc < done_cyc && g < 200) begin
            slot();
            g++;
        end
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin : stim
        int n;
        logic [5:0]  op;
        logic [31:0] a, b;

        // Reset
        repeat (3) slot();
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_ready", 64'(op_ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b1;
        slot();

        // DIV -7 / 2 with busy length measured from the DUT
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            slot();
        end
        check("div_busy_len", 64'(n), 64'd32);
        check("div_done", 64'(done), 64'd1);
        check("div_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_hi", 64'(hi), 64'hFFFF_FFFF);

        // MULTU max * max, latency measured from the DUT
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            n++;
            slot();
        end
        check("multu_wait", 64'(n), 64'(MUL_WAIT));
        check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        check("multu_lo", 64'(lo), 64'h0000_0001);

        // MULT -2 * 3
        issue(OP_MULT, 32'hFFFF_FFFE, 32'd3);
        wait_done();
        check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo), 64'hFFFF_FFFA);

        // DIVU 100 / 0
        issue(OP_DIVU, 32'd100, 32'd0);
        check("div0_done", 64'(done), 64'd1);
        check("div0_busy", 64'(busy), 64'd0);
        check("div0_hi", 64'(hi), 64'd100);
        check("div0_lo", 64'(lo), 64'hFFFF_FFFF);

        // Overflowing signed divide
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done();
        check("divovf_lo", 64'(lo), 64'h8000_0000);
        check("divovf_hi", 64'(hi), 64'd0);

        // MTHI, then a divide flushed on step 10, then MFHI
        issue(OP_MTHI, 32'h0000_1234, 32'd0);
        issue(OP_DIV, 32'd50, 32'd7);
        flush_after(9);
        check("flush_ready", 64'(op_ready), 64'd1);
        check("flush_done", 64'(done), 64'd0);
        check("flush_hi", 64'(hi), 64'h1234);
        issue(OP_MFHI, 32'd0, 32'd0);
        check("mfhi_result", 64'(result), 64'h1234);
        check("mfhi_done", 64'(done), 64'd1);

        // DIVU 50/7 then MFLO accepted in the done cycle
        issue(OP_DIVU, 32'd50, 32'd7);
        wait_done();
        issue(OP_MFLO, 32'd0, 32'd0);
        check("mflo_result", 64'(result), 64'd7);
        check("mflo_done", 64'(done), 64'd1);
        idle_flush(OP_MFHI, 32'd0, 32'd0);
        check("idleflush_done", 64'(done), 64'd0);

        // Flush on the final step
        issue(OP_DIVU, 32'hDEAD_BEEF, 32'd3);
        flush_after(31);

        // Randomized phase
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 99) < 15) begin
                op = 6'($urandom);
            end else begin
                op = ops[$urandom_range(0, 7)];
            end
            a = rnd_operand();
            b = rnd_operand();
            issue(op, a, b);
            if (last_lat == 32 && $urandom_range(0, 5) == 0) begin
                flush_after($urandom_range(0, 31));
            end
            if ($urandom_range(0, 9) == 0) begin
                idle_flush(ops[$urandom_range(0, 7)], $urandom, $urandom);
            end
            repeat ($urandom_range(0, 2)) slot();
        end

        // Reset in the middle of a divide
        issue(OP_MTLO, 32'hCAFE_F00D, 32'd0);
        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (5) slot();
        rst      = 1'b0;
        busy_lo  = 1;
        busy_hi  = 0;
        done_cyc = -1;
        repeat (2) slot();
        rst = 1'b1;
        slot();
        check("midrst_lo", 64'(lo), 64'd0);
        check("midrst_ready", 64'(op_ready), 64'd1);
        issue(OP_MTHI, 32'h0BAD_F00D, 32'd0);
        check("postrst_hi", 64'(hi), 64'h0BAD_F00D);
        repeat (3) slot();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
